scaler_ctrl: RTL and testbench

Frame-synchronous controller in front of the `scaler` datapath. It gates the input video so the scaler only sees whole frames, and it shadows the h/v scale-step configuration so that configuration changes land only on frame boundaries. It also measures the input line width, drives the scaler's `reg_v_scale_inline_size`, and reports per-frame statistics and line-width errors.

---
 rtl/scaler_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_scaler_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_ctrl.sv
// Frame-synchronous video gate and config shadow in front of the scaler datapath.
// Latency: video passes through one register stage; config lands only between frames.
// Backpressure: cfg_ready_o stays low while an accepted config waits for a frame boundary.
module scaler_ctrl #(
    parameter int PIXEL_WIDTH          = 8,
    parameter int LINE_IN_SIZE_MAX     = 1024,
    parameter bit AUTO_INLINE          = 1'b1,
    parameter int DEFAULT_INLINE_WIDTH = 15,
    parameter int DEFAULT_STEP         = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            cfg_h_step_i,
    input  logic [15:0]            cfg_v_step_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    output logic                   cfg_err_o,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic [15:0]            reg_h_scale_step_o,
    output logic [15:0]            reg_v_scale_step_o,
    output logic [15:0]            reg_v_scale_inline_size_o,
    output logic [15:0]            stat_line_width_o,
    output logic [15:0]            stat_line_cnt_o,
    output logic                   stat_err_o,
    output logic                   frame_done_o
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

    localparam logic [15:0] STEP_RST   = 16'(DEFAULT_STEP);
    localparam logic [15:0] INLINE_RST = 16'(DEFAULT_INLINE_WIDTH - 1);
    localparam logic [31:0] SIZE_MAX   = 32'(LINE_IN_SIZE_MAX);

    state_t state_q, state_d;
    logic vs_in_q, vs_in_d, hs_in_q, hs_in_d;
    logic en_q, en_d;
    logic [15:0] h_step_q, h_step_d, v_step_q, v_step_d, inline_q, inline_d;
    logic pend_q, pend_d, pend_en_q, pend_en_d;
    logic [15:0] pend_h_q, pend_h_d, pend_v_q, pend_v_d;
    logic cfg_err_q, cfg_err_d;
    logic [PIXEL_WIDTH-1:0] out_do_q, out_do_d;
    logic out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;
    logic [15:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, ref_w_q, ref_w_d;
    logic have_ref_q, have_ref_d, err_q, err_d;
    logic [15:0] stat_w_q, stat_w_d, stat_lines_q, stat_lines_d;
    logic done_q, done_d;

    logic sof, eof, line_end, cfg_ok, cfg_take, pass, frame_start, frame_end, apply, en_next;
    logic [15:0] pix_now, pix_base, lines_base, ref_base;
    logic have_ref_base, err_base;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        sof         = !vs_in_q && vs_i;
        eof         = vs_in_q && !vs_i;
        line_end    = !hs_in_q && hs_i;
        cfg_ok      = (cfg_h_step_i != 16'd0) && (cfg_v_step_i != 16'd0);
        cfg_take    = cfg_valid_i && !pend_q;
        frame_start = (state_q == WAIT_SOF) && sof && en_q;
        frame_end   = (state_q == ACTIVE) && eof;
        pass        = (state_q == ACTIVE) || frame_start;
        // Outside a frame a pending config lands at once; inside, only on the EOF cycle.
        apply       = pend_q && ((state_q != ACTIVE) || eof);
        en_next     = apply ? pend_en_q : en_q;

        pix_base      = frame_start ? 16'd0 : pix_cnt_q;
        lines_base    = frame_start ? 16'd0 : line_cnt_q;
        ref_base      = frame_start ? 16'd0 : ref_w_q;
        have_ref_base = frame_start ? 1'b0 : have_ref_q;
        err_base      = frame_start ? 1'b0 : err_q;
        pix_now       = sat_inc(pix_base, de_i);
    end

    always_comb begin
        state_d      = state_q;
        vs_in_d      = vs_i;
        hs_in_d      = hs_i;
        en_d         = en_q;
        h_step_d     = h_step_q;
        v_step_d     = v_step_q;
        inline_d     = inline_q;
        pend_d       = pend_q;
        pend_en_d    = pend_en_q;
        pend_h_d     = pend_h_q;
        pend_v_d     = pend_v_q;
        cfg_err_d    = cfg_take && !cfg_ok;
        out_do_d     = '0;
        out_de_d     = 1'b0;
        out_hs_d     = 1'b1;
        out_vs_d     = 1'b0;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        ref_w_d      = ref_w_q;
        have_ref_d   = have_ref_q;
        err_d        = err_q;
        stat_w_d     = stat_w_q;
        stat_lines_d = stat_lines_q;
        done_d       = frame_end;

        if (cfg_take && cfg_ok) begin
            pend_d    = 1'b1;
            pend_h_d  = cfg_h_step_i;
            pend_v_d  = cfg_v_step_i;
            pend_en_d = cfg_en_i;
        end

        if (apply) begin
            pend_d   = 1'b0;
            h_step_d = pend_h_q;
            v_step_d = pend_v_q;
            en_d     = pend_en_q;
            if (pend_en_q && !en_q) begin
                inline_d = INLINE_RST;
            end
        end

        if (pass) begin
            out_do_d   = di_i;
            out_de_d   = de_i;
            out_hs_d   = hs_i;
            out_vs_d   = vs_i;
            pix_cnt_d  = pix_now;
            line_cnt_d = lines_base;
            ref_w_d    = ref_base;
            have_ref_d = have_ref_base;
            err_d      = err_base;
            if (line_end) begin
                pix_cnt_d = 16'd0;
                // Empty lines are vertical blanking inside vs: neither counted nor checked.
                if (pix_now != 16'd0) begin
                    line_cnt_d = sat_inc(lines_base, 1'b1);
                    if (!have_ref_base) begin
                        ref_w_d    = pix_now;
                        have_ref_d = 1'b1;
                    end else if (pix_now != ref_base) begin
                        err_d = 1'b1;
                    end
                    if ({16'd0, pix_now} > SIZE_MAX) begin
                        err_d = 1'b1;
                    end
                end
            end
        end

        if (frame_end) begin
            stat_w_d     = ref_w_d;
            stat_lines_d = line_cnt_d;
            if (AUTO_INLINE && !err_d && ref_w_d != 16'd0) begin
                inline_d = ref_w_d - 16'd1;
            end
        end

        case (state_q)
            IDLE:     if (en_q) state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (!en_q)    state_d = IDLE;
                else if (sof) state_d = ACTIVE;
            end
            ACTIVE:   if (eof) state_d = en_next ? WAIT_SOF : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vs_in_q      <= 1'b1;
            hs_in_q      <= 1'b1;
            en_q         <= 1'b0;
            h_step_q     <= STEP_RST;
            v_step_q     <= STEP_RST;
            inline_q     <= INLINE_RST;
            pend_q       <= 1'b0;
            pend_en_q    <= 1'b0;
            pend_h_q     <= 16'd0;
            pend_v_q     <= 16'd0;
            cfg_err_q    <= 1'b0;
            out_do_q     <= '0;
            out_de_q     <= 1'b0;
            out_hs_q     <= 1'b1;
            out_vs_q     <= 1'b0;
            pix_cnt_q    <= 16'd0;
            line_cnt_q   <= 16'd0;
            ref_w_q      <= 16'd0;
            have_ref_q   <= 1'b0;
            err_q        <= 1'b0;
            stat_w_q     <= 16'd0;
            stat_lines_q <= 16'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_in_q      <= vs_in_d;
            hs_in_q      <= hs_in_d;
            en_q         <= en_d;
            h_step_q     <= h_step_d;
            v_step_q     <= v_step_d;
            inline_q     <= inline_d;
            pend_q       <= pend_d;
            pend_en_q    <= pend_en_d;
            pend_h_q     <= pend_h_d;
            pend_v_q     <= pend_v_d;
            cfg_err_q    <= cfg_err_d;
            out_do_q     <= out_do_d;
            out_de_q     <= out_de_d;
            out_hs_q     <= out_hs_d;
            out_vs_q     <= out_vs_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            ref_w_q      <= ref_w_d;
            have_ref_q   <= have_ref_d;
            err_q        <= err_d;
            stat_w_q     <= stat_w_d;
            stat_lines_q <= stat_lines_d;
            done_q       <= done_d;
        end
    end

    assign cfg_ready_o               = !pend_q;
    assign cfg_err_o                 = cfg_err_q;
    assign do_o                      = out_do_q;
    assign de_o                      = out_de_q;
    assign hs_o                      = out_hs_q;
    assign vs_o                      = out_vs_q;
    assign reg_h_scale_step_o        = h_step_q;
    assign reg_v_scale_step_o        = v_step_q;
    assign reg_v_scale_inline_size_o = inline_q;
    assign stat_line_width_o         = stat_w_q;
    assign stat_line_cnt_o           = stat_lines_q;
    assign stat_err_o                = err_q;
    assign frame_done_o              = done_q;
endmodule

// File: tb/tb_scaler_ctrl.sv
// Randomised frame-level bench for scaler_ctrl against a frame-granular reference model.
module tb_scaler_ctrl;
    localparam int PW   = 8;
    localparam int LMAX = 30;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] cfg_h_step_i, cfg_v_step_i;
    logic cfg_en_i, cfg_valid_i, cfg_ready_o, cfg_err_o;
    logic [PW-1:0] di_i, do_o;
    logic de_i, hs_i, vs_i, de_o, hs_o, vs_o;
    logic [15:0] reg_h_scale_step_o, reg_v_scale_step_o, reg_v_scale_inline_size_o;
    logic [15:0] stat_line_width_o, stat_line_cnt_o;
    logic stat_err_o, frame_done_o;

    always #5 clk = ~clk;

    scaler_ctrl #(
        .PIXEL_WIDTH(PW), .LINE_IN_SIZE_MAX(LMAX), .AUTO_INLINE(1'b1),
        .DEFAULT_INLINE_WIDTH(15), .DEFAULT_STEP(128)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_h_step_i(cfg_h_step_i), .cfg_v_step_i(cfg_v_step_i),
        .cfg_en_i(cfg_en_i), .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o), .cfg_err_o(cfg_err_o),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .reg_h_scale_step_o(reg_h_scale_step_o), .reg_v_scale_step_o(reg_v_scale_step_o),
        .reg_v_scale_inline_size_o(reg_v_scale_inline_size_o),
        .stat_line_width_o(stat_line_width_o), .stat_line_cnt_o(stat_line_cnt_o),
        .stat_err_o(stat_err_o), .frame_done_o(frame_done_o)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state, updated only at frame / config granularity.
    int m_h = 128, m_v = 128, m_inline = 14, m_sw = 0, m_sc = 0;
    bit m_en = 1'b0, m_serr = 1'b0;

    bit exp_pass = 1'b0;
    int fr_h, fr_v, fr_inl;
    int mon_bad = 0, done_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic void apply_cfg(input int h, input int v, input bit en);
        if (en && !m_en) m_inline = 14;
        m_h  = h;
        m_v  = v;
        m_en = en;
    endfunction

    // One clock: drive inputs, take the edge, then inspect outputs 1 time unit later.
    task automatic cyc(input logic de, input logic hs, input logic vs, input logic [PW-1:0] d);
        de_i = de; hs_i = hs; vs_i = vs; di_i = d;
        @(posedge clk);
        #1;
        if (exp_pass) begin
            if (de_o !== de || hs_o !== hs || vs_o !== vs || do_o !== d) mon_bad++;
            if (vs && (reg_h_scale_step_o !== 16'(fr_h) || reg_v_scale_step_o !== 16'(fr_v) ||
                       reg_v_scale_inline_size_o !== 16'(fr_inl))) mon_bad++;
        end else if (de_o !== 1'b0 || hs_o !== 1'b1 || vs_o !== 1'b0 || do_o !== '0) begin
            mon_bad++;
        end
        if (frame_done_o === 1'b1) done_seen++;
    endtask

    task automatic drive_cfg(input logic [15:0] h, input logic [15:0] v, input logic en);
        cfg_h_step_i = h; cfg_v_step_i = v; cfg_en_i = en; cfg_valid_i = 1'b1;
    endtask

    task automatic after_cfg(input string tag, input bit ok);
        cfg_valid_i = 1'b0;
        check_eq({tag, "_ready"}, cfg_ready_o, !ok);
        check_eq({tag, "_err"}, cfg_err_o, !ok);
    endtask

    // wr_pos: 0 none, 1 in the gap before SOF, 2 on the SOF cycle, 3 mid-frame.
    task automatic run_frame(input int nl, input int w, input int bad_ln, input int bad_w,
                             input int blank_ln, input int wr_pos,
                             input logic [15:0] wh, input logic [15:0] wv, input logic we);
        bit passed, ok, pend, err;
        int lw, ref_w, nz, p;
        ok = (wh != 16'd0) && (wv != 16'd0);
        pend = 1'b0; err = 1'b0; ref_w = 0; nz = 0;
        exp_pass = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 && wr_pos == 1) begin
                drive_cfg(wh, wv, we);
                cyc(1'b0, 1'b1, 1'b0, '0);
                after_cfg("gap_cfg", ok);
                check_eq("gap_cfg_hold", reg_h_scale_step_o, m_h);
                if (ok) apply_cfg(wh, wv, we);
            end else begin
                cyc(1'b0, 1'b1, 1'b0, '0);
            end
            if (i == 1 && wr_pos == 1) begin
                check_eq("gap_cfg_h", reg_h_scale_step_o, m_h);
                check_eq("gap_cfg_v", reg_v_scale_step_o, m_v);
                check_eq("gap_cfg_ready_back", cfg_ready_o, 1);
            end
        end

        passed = m_en;
        fr_h = m_h; fr_v = m_v; fr_inl = m_inline;
        mon_bad = 0; done_seen = 0;
        exp_pass = passed;
        if (wr_pos == 2) drive_cfg(wh, wv, we);
        cyc(1'b0, 1'b1, 1'b1, '0);
        if (wr_pos == 2) begin
            after_cfg("sof_cfg", ok);
            if (ok) begin
                if (passed) pend = 1'b1;
                else apply_cfg(wh, wv, we);
            end
        end
        if (passed) check_eq("sof_err_clear", stat_err_o, 0);
        cyc(1'b0, 1'b1, 1'b1, '0);

        for (int ln = 0; ln < nl; ln++) begin
            lw = (ln == blank_ln) ? 0 : (ln == bad_ln) ? bad_w : w;
            if (wr_pos == 3 && ln == nl / 2) begin
                drive_cfg(wh, wv, we);
                cyc(1'b0, 1'b0, 1'b1, '0);
                after_cfg("mid_cfg", ok);
                if (ok) begin
                    if (passed) pend = 1'b1;
                    else apply_cfg(wh, wv, we);
                end
            end
            if (lw == 0) begin
                cyc(1'b0, 1'b0, 1'b1, '0);
                cyc(1'b0, 1'b0, 1'b1, '0);
            end else begin
                p = 0;
                while (p < lw) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cyc(1'b0, 1'b0, 1'b1, '0);
                    end else begin
                        cyc(1'b1, 1'b0, 1'b1, PW'($urandom));
                        p++;
                    end
                end
            end
            cyc(1'b0, 1'b1, 1'b1, '0);
            if (lw != 0) begin
                nz++;
                if (nz == 1) ref_w = lw;
                else if (lw != ref_w) err = 1'b1;
                if (lw > LMAX) err = 1'b1;
            end
            check_eq("line_err", stat_err_o, passed ? err : m_serr);
            cyc(1'b0, 1'b1, 1'b1, '0);
        end
        check_eq("pre_eof_ready", cfg_ready_o, !pend);
        cyc(1'b0, 1'b1, 1'b0, '0);
        exp_pass = 1'b0;

        if (passed) begin
            m_sw = ref_w; m_sc = nz; m_serr = err;
            if (!err && ref_w >= 1) m_inline = ref_w - 1;
            if (pend) apply_cfg(wh, wv, we);
        end
        check_eq("frame_monitor", mon_bad, 0);
        check_eq("frame_done_cnt", done_seen, passed ? 1 : 0);
        check_eq("stat_width", stat_line_width_o, m_sw);
        check_eq("stat_lines", stat_line_cnt_o, m_sc);
        check_eq("stat_err", stat_err_o, m_serr);
        check_eq("h_step", reg_h_scale_step_o, m_h);
        check_eq("v_step", reg_v_scale_step_o, m_v);
        check_eq("inline", reg_v_scale_inline_size_o, m_inline);
        check_eq("post_ready", cfg_ready_o, 1);
    endtask

    initial begin
        int nl, w, bad_ln, bad_w, blank_ln, wp;
        logic [15:0] wh, wv;
        rst_n = 1'b0;
        cfg_h_step_i = 16'd0; cfg_v_step_i = 16'd0; cfg_en_i = 1'b0; cfg_valid_i = 1'b0;
        di_i = '0; de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1;
        mon_bad = 0; done_seen = 0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i % 2), 1'b1, '0);
        rst_n = 1'b1;
        check_eq("rst_do", do_o, 0);
        check_eq("rst_de", de_o, 0);
        check_eq("rst_hs", hs_o, 1);
        check_eq("rst_vs", vs_o, 0);
        check_eq("rst_h", reg_h_scale_step_o, 128);
        check_eq("rst_v", reg_v_scale_step_o, 128);
        check_eq("rst_inline", reg_v_scale_inline_size_o, 14);
        check_eq("rst_stat_w", stat_line_width_o, 0);
        check_eq("rst_stat_c", stat_line_cnt_o, 0);
        check_eq("rst_stat_err", stat_err_o, 0);
        check_eq("rst_ready", cfg_ready_o, 1);
        check_eq("rst_cfg_err", cfg_err_o, 0);
        check_eq("rst_done", frame_done_o, 0);

        // Reset released mid-frame: enabling now must not open the gate before a real SOF.
        for (int ln = 0; ln < 4; ln++) begin
            for (int p = 0; p < 5; p++) cyc(1'b1, 1'b0, 1'b1, PW'($urandom));
            cyc(1'b0, 1'b1, 1'b1, '0);
            if (ln == 1) begin
                drive_cfg(16'd192, 16'd192, 1'b1);
                cyc(1'b0, 1'b1, 1'b1, '0);
                after_cfg("rst_cfg", 1'b1);
                check_eq("rst_cfg_hold", reg_h_scale_step_o, 128);
                cyc(1'b0, 1'b1, 1'b1, '0);
                apply_cfg(192, 192, 1'b1);
                check_eq("rst_cfg_h", reg_h_scale_step_o, m_h);
                check_eq("rst_cfg_ready_back", cfg_ready_o, 1);
            end
        end
        check_eq("partial_blank", mon_bad, 0);
        check_eq("partial_no_done", done_seen, 0);

        run_frame(24, 24, -1, 0, -1, 3, 16'd96, 16'd192, 1'b1);
        run_frame(24, 24, -1, 0, -1, 0, 16'd0, 16'd0, 1'b0);
        run_frame(6, 24, -1, 0, -1, 3, 16'd96, 16'd192, 1'b0);
        run_frame(6, 24, -1, 0, -1, 0, 16'd0, 16'd0, 1'b0);
        run_frame(8, 24, 4, 23, -1, 1, 16'd192, 16'd192, 1'b1);
        run_frame(4, 10, -1, 0, -1, 1, 16'd0, 16'd192, 1'b1);
        run_frame(4, 10, -1, 0, 1, 2, 16'd64, 16'd64, 1'b1);
        run_frame(3, 31, -1, 0, -1, 0, 16'd0, 16'd0, 1'b0);
        run_frame(3, 30, -1, 0, -1, 0, 16'd0, 16'd0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            nl       = $urandom_range(2, 8);
            w        = ($urandom_range(0, 4) == 0) ? $urandom_range(29, 32) : $urandom_range(1, 28);
            bad_ln   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nl - 1) : -1;
            bad_w    = ($urandom_range(0, 1) == 0) ? w + 1 : w - 1;
            blank_ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
            wp       = $urandom_range(0, 3);
            wh       = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1023));
            wv       = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1023));
            run_frame(nl, w, bad_ln, bad_w, blank_ln, wp, wh, wv, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
